// File: rtl/gb_timer_pkg.sv
// Shared timer definitions: register map, TAC clock-select encoding, reload FSM states.
// Latency: n/a (types and a pure helper only); no backpressure.
package gb_timer_pkg;

    localparam logic [15:0] ADR_DIV  = 16'hFF04;
    localparam logic [15:0] ADR_TIMA = 16'hFF05;
    localparam logic [15:0] ADR_TMA  = 16'hFF06;
    localparam logic [15:0] ADR_TAC  = 16'hFF07;

    // Encoding names reflect which divider bit feeds the tick.
    typedef enum logic [1:0] {
        TAC_SEL_9 = 2'b00,
        TAC_SEL_3 = 2'b01,
        TAC_SEL_5 = 2'b10,
        TAC_SEL_7 = 2'b11
    } tac_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_RELOAD = 2'b10
    } state_t;

    function automatic logic tick_of(input logic [15:0] div, input logic [2:0] tac);
        logic bit_v;
        bit_v = div[9];
        case (tac_sel_t'(tac[1:0]))
            TAC_SEL_9: bit_v = div[9];
            TAC_SEL_3: bit_v = div[3];
            TAC_SEL_5: bit_v = div[5];
            TAC_SEL_7: bit_v = div[7];
        endcase
        return tac[2] & bit_v;
    endfunction

endpackage

// File: rtl/gb_timer_div.sv
// Free-running 16-bit divider plus falling-edge detector on the TAC-selected tick; tick_fall is one cycle after the drop.
// No backpressure. GB_TIMER_GLITCH_EN lets DIV/TAC writes that drop the tick produce a fall.
module gb_timer_div
    import gb_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       div_wr,
    input  logic       tac_wr,
    input  logic [2:0] tac_cur,
    input  logic [2:0] tac_nxt,
    output logic [7:0] div_hi,
    output logic       tick_fall
);

    logic [15:0] div_q, div_d;
    logic        tick_hist_q, tick_hist_d;
    logic        tick_cur;

    always_comb begin
        div_d    = div_wr ? 16'h0000 : div_q + 16'd1;
        tick_cur = tick_of(div_q, tac_cur);
`ifdef GB_TIMER_GLITCH_EN
        tick_hist_d = tick_cur;
`else
        // Resync history to the post-write tick so a register write never looks like an edge.
        tick_hist_d = (div_wr || tac_wr) ? tick_of(div_d, tac_nxt) : tick_cur;
`endif
    end

`ifdef GB_TIMER_GLITCH_EN
    logic unused_glitch;
    assign unused_glitch = ^{tac_wr, tac_nxt};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= 16'h0000;
            tick_hist_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            tick_hist_q <= tick_hist_d;
        end
    end

    assign div_hi    = div_q[15:8];
    assign tick_fall = tick_hist_q & ~tick_cur;

endmodule

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer with delayed TMA reload and irq; writes land at the strobe edge, reads are combinational.
// No backpressure. GB_TIMER_GLITCH_EN enables DMG-style increments on tick-dropping DIV/TAC writes.
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter int RELOAD_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adr,
    input  logic [7:0]  din,
    input  logic        p_wr,
    input  logic        p_rd,
    output logic [7:0]  dout,
    output logic        sel,
    output logic        irq,
    input  logic        iack
);

    localparam int CNT_W = (RELOAD_DELAY > 2) ? $clog2(RELOAD_DELAY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELOAD_DELAY - 2);

    logic [7:0]       tima_q, tima_d;
    logic [7:0]       tma_q, tma_d;
    logic [2:0]       tac_q, tac_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;

    logic       wr_div, wr_tima, wr_tma, wr_tac;
    logic [7:0] div_hi;
    logic       tick_fall;

    assign sel     = (adr[15:2] == ADR_DIV[15:2]);
    assign wr_div  = p_wr && (adr == ADR_DIV);
    assign wr_tima = p_wr && (adr == ADR_TIMA);
    assign wr_tma  = p_wr && (adr == ADR_TMA);
    assign wr_tac  = p_wr && (adr == ADR_TAC);

    gb_timer_div u_div (
        .clk       (clk),
        .reset     (reset),
        .div_wr    (wr_div),
        .tac_wr    (wr_tac),
        .tac_cur   (tac_q),
        .tac_nxt   (tac_d),
        .div_hi    (div_hi),
        .tick_fall (tick_fall)
    );

    always_comb begin
        dout = 8'hFF;
        if (sel && p_rd) begin
            if (adr == ADR_DIV)       dout = div_hi;
            else if (adr == ADR_TIMA) dout = tima_q;
            else if (adr == ADR_TMA)  dout = tma_q;
            else                      dout = {5'b11111, tac_q};
        end
    end

    always_comb begin
        tima_d  = tima_q;
        tma_d   = tma_q;
        tac_d   = tac_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = irq_q;

        if (wr_tma) tma_d = din;
        if (wr_tac) tac_d = din[2:0];
        if (iack)   irq_d = 1'b0;

        // Ticks are ignored outside IDLE: TIMA sits at 00 until the reload lands.
        case (state_q)
            ST_IDLE: begin
                if (wr_tima) begin
                    tima_d = din;
                end else if (tick_fall) begin
                    tima_d = tima_q + 8'd1;
                    if (tima_q == 8'hFF) begin
                        state_d = ST_DELAY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_DELAY: begin
                if (wr_tima) begin
                    tima_d  = din;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELOAD: begin
                tima_d  = tma_d;
                irq_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: doc/gb_timer.md
GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 SHALL have parameter RELOAD_DELAY, default 4: clk cycles between TIMA overflow and TMA reload.
REQ-002 SHALL have port clk, input, 1: single clock, one T-cycle per rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port adr, input, 16: CPU bus address.
REQ-005 SHALL have port din, input, 8: write data from CPU dout.
REQ-006 SHALL have port p_wr, input, 1: write strobe, sampled at clk rise.
REQ-007 SHALL have port p_rd, input, 1: read strobe.
REQ-008 SHALL have port dout, output, 8: read data to CPU din.
REQ-009 SHALL have port sel, output, 1: address hits FF04-FF07.
REQ-010 SHALL have port irq, output, 1: timer interrupt request (CPU irq bit 2).
REQ-011 SHALL have port iack, input, 1: interrupt acknowledge (CPU iack bit 2).

Function
REQ-012 SHALL keep a 16-bit divider, +1 every clk, wrapping FFFF->0000.
REQ-013 SHALL map FF04 DIV (read = divider[15:8]), FF05 TIMA, FF06 TMA, FF07 TAC (bits 2:0 used; reads return 1 in bits 7:3).
REQ-014 SHALL drive sel=1 combinationally iff adr is FF04-FF07; dout = register when sel&p_rd, else FF.
REQ-015 SHALL make writes take effect at the clk edge where p_wr&sel; any write to DIV clears the divider to 0000.
REQ-016 SHALL form tick = TAC[2] & divider bit (TAC[1:0]: 00->9, 01->3, 10->5, 11->7) and increment TIMA on each 1->0 transition of tick.
REQ-017 SHALL run reload FSM IDLE -> DELAY (TIMA=00 on overflow FF->00, count RELOAD_DELAY-1 clks) -> RELOAD (TIMA<=TMA, irq<=1) -> IDLE.
REQ-018 SHALL cancel the pending reload and the irq when TIMA is written during DELAY; the written value stands.
REQ-019 SHALL ignore TIMA writes in the RELOAD cycle (TMA wins); a TMA write in RELOAD loads the new TMA into TIMA.
REQ-020 SHALL hold irq high until the clk edge after iack=1; a new RELOAD in the same cycle as iack keeps irq=1.
REQ-021 SHALL give a tick edge in the last DELAY cycle no effect on TIMA.

Reset
REQ-022 SHALL, on reset, clear divider=0000, TIMA=00, TMA=00, TAC=0, FSM=IDLE, irq=0 and the tick-history flop=0.
REQ-023 SHALL let reset override every write, tick and reload in the same cycle, including mid-DELAY.

Configuration
REQ-024 SHALL use macro GB_TIMER_GLITCH_EN.
REQ-025 With GB_TIMER_GLITCH_EN defined, SHALL let a DIV write or TAC write that drops tick 1->0 increment TIMA (DMG behaviour).
REQ-026 Without GB_TIMER_GLITCH_EN, SHALL increment TIMA only on divider-count edges; tick history reloads on DIV/TAC writes with no increment.

Structure
REQ-027 SHALL place register address constants (FF04-FF07), a tac_sel_t enum and the FSM state enum in package gb_timer_pkg.
REQ-028 SHALL implement divider plus tick falling-edge detector as sub-module gb_timer_div; TIMA/TMA/TAC, FSM and bus decode stay in gb_timer.

Verification
REQ-029 SHALL check: TAC=05 (bit3), TIMA=00 -> TIMA=01 16 clks after the first tick fall, then +1 every 16 clks.
REQ-030 SHALL check: TMA=AB, TIMA=FF, TAC=05 -> TIMA reads 00 for 4 clks, then AB; irq rises with reload, drops after iack pulse.
REQ-031 SHALL check: write TIMA=42 during DELAY -> TIMA=42, no reload, irq stays 0.
REQ-032 SHALL check: TMA write 77 in RELOAD cycle -> TIMA=77.
REQ-033 SHALL check: divider bit3=1, TAC=05, write DIV -> TIMA +1 with GB_TIMER_GLITCH_EN, unchanged without.
REQ-034 SHALL check: read FF07 with TAC=05 -> dout=FD; read FF08 -> sel=0, dout=FF; reset mid-DELAY -> TIMA=00, irq=0.
